// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the VGA framebuffer write path.
// Geometry defaults to 640x480 with 8-bit pixels in an M10k framebuffer.
// It also holds the arbiter state and grant enums and a saturating
// counter helper.
package fb_pkg;

    localparam int WIDTH    = 640;
    localparam int HEIGHT   = 480;
    localparam int FB_DEPTH = WIDTH * HEIGHT;
    localparam int ADDR_W   = 19;
    localparam int COLOR_W  = 8;
    localparam int COORD_W  = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        GNT_CLEAR = 1'b0,
        GNT_PLOT  = 1'b1
    } grant_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: combinational pixel-coordinate to framebuffer-address mapping.
// Ports:
//   x, y      in   pixel column / row
//   addr      out  FB_WIDTH*y + x, truncated to ADDR_W bits
//   in_range  out  1 when x < FB_WIDTH and y < FB_HEIGHT
// addr is only meaningful when in_range is set. Out-of-range
// coordinates may wrap.
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::WIDTH,
    parameter int FB_HEIGHT = fb_pkg::HEIGHT
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_range
);

    // Row-major address and bounds check.
    always_comb begin
        addr     = ADDR_W'(FB_WIDTH) * ADDR_W'(y) + ADDR_W'(x);
        in_range = (x < COORD_W'(FB_WIDTH)) && (y < COORD_W'(FB_HEIGHT));
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the single M10k write port between the built-in
// full-frame clear engine and an external pixel plotter.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clear_start/color     pulse to start or restart a clear with a fill value
//   plot_valid/ready      plot handshake; plot_x/plot_y/plot_color payload
//   wr_en/addr/data       registered M10k write port
//   clear_busy            high while the clear sweep is running
//   frame_done            one-cycle pulse alongside the last clear write
//   drop_count            saturating count of out-of-range plots
// A plot is only let through behind the clear pointer. This ensures a sweep
// never overwrites a fresh pixel. During a sweep, plot and clear grants
// alternate, so the clear advances at least every second cycle.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::WIDTH,
    parameter int FB_HEIGHT = fb_pkg::HEIGHT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               plot_valid,
    output logic               plot_ready,
    input  logic [COORD_W-1:0] plot_x,
    input  logic [COORD_W-1:0] plot_y,
    input  logic [COLOR_W-1:0] plot_color,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               clear_busy,
    output logic               frame_done,
    output logic [15:0]        drop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    state_t             state_r;
    grant_t             last_grant_r;
    logic [ADDR_W-1:0]  ptr_r;
    logic [COLOR_W-1:0] fill_color_r;
    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [COLOR_W-1:0] wr_data_r;
    logic               frame_done_r;
    logic [15:0]        drop_count_r;

    logic [ADDR_W-1:0]  plot_addr_s;
    logic               plot_in_range_s;
    logic               plot_eligible_s;
    logic               plot_fire_s;

    fb_addr_calc #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_addr_calc (
        .x        (plot_x),
        .y        (plot_y),
        .addr     (plot_addr_s),
        .in_range (plot_in_range_s)
    );

    // Ready decode. It never looks at plot_valid. A clear_start always
    // takes the cycle.
    always_comb begin
        plot_ready      = 1'b0;
        plot_eligible_s = !plot_in_range_s || (plot_addr_s < ptr_r);
        if (clear_start) begin
            plot_ready = 1'b0;
        end else begin
            case (state_r)
                IDLE:    plot_ready = 1'b1;
                CLEAR:   plot_ready = plot_eligible_s && (last_grant_r == GNT_CLEAR);
                default: plot_ready = 1'b0;
            endcase
        end
        plot_fire_s = plot_valid && plot_ready;
    end

    // Arbiter FSM, clear pointer, registered write port and drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= GNT_CLEAR;
            ptr_r        <= '0;
            fill_color_r <= '0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            frame_done_r <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            wr_en_r      <= 1'b0;
            frame_done_r <= 1'b0;

            // Accepted plot: out-of-range ones occupy the slot but do not write.
            if (plot_fire_s) begin
                wr_en_r      <= plot_in_range_s;
                wr_addr_r    <= plot_addr_s;
                wr_data_r    <= plot_color;
                last_grant_r <= GNT_PLOT;
                if (!plot_in_range_s) begin
                    drop_count_r <= sat_inc16(drop_count_r);
                end
            end

            case (state_r)
                IDLE: begin
                    if (clear_start) begin
                        state_r      <= CLEAR;
                        ptr_r        <= '0;
                        fill_color_r <= clear_color;
                        last_grant_r <= GNT_CLEAR;
                    end
                end
                CLEAR: begin
                    if (clear_start) begin
                        // Restart from the top with the new color; no grant this cycle.
                        ptr_r        <= '0;
                        fill_color_r <= clear_color;
                        last_grant_r <= GNT_CLEAR;
                    end else if (!plot_fire_s) begin
                        wr_en_r      <= 1'b1;
                        wr_addr_r    <= ptr_r;
                        wr_data_r    <= fill_color_r;
                        last_grant_r <= GNT_CLEAR;
                        if (ptr_r == LAST_ADDR) begin
                            state_r      <= IDLE;
                            ptr_r        <= '0;
                            frame_done_r <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ptr_r   <= '0;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign drop_count = drop_count_r;
    assign clear_busy = (state_r == CLEAR);

endmodule
